// File: rtl/reg_timer_core_if.sv
// Register-bus bundle between the TL-UL register adapter and the timer core.
interface reg_timer_core_if #(
   parameter int RegAw = 8,
   parameter int RegDw = 32
);
   logic               re_i;
   logic               we_i;
   logic [RegAw-1:0]   addr_i;
   logic [RegDw-1:0]   wdata_i;
   logic [RegDw/8-1:0] be_i;
   logic [RegDw-1:0]   rdata_o;
   logic               error_o;

   modport master (
      output re_i, we_i, addr_i, wdata_i, be_i,
      input  rdata_o, error_o
   );

   modport slave (
      input  re_i, we_i, addr_i, wdata_i, be_i,
      output rdata_o, error_o
   );
endinterface

// File: rtl/reg_timer_core.sv
// Prescaled 32-bit up-counter with compare interrupt behind a simple register bus.
module reg_timer_core #(
   parameter int RegAw = 8,
   parameter int RegDw = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   reg_timer_core_if.slave bus,
   output logic            intr_o
);
   localparam int IdxW = RegAw - 2;

   logic [1:0]       ctrl_q, ctrl_d;
   logic [11:0]      presc_q, presc_d;
   logic [RegDw-1:0] count_q, count_d;
   logic [RegDw-1:0] cmp_q, cmp_d;
   logic             intr_q, intr_d;
   logic [11:0]      pcnt_q, pcnt_d;

   logic [IdxW-1:0]  idx;
   logic             sel_ctrl, sel_presc, sel_count, sel_cmp, sel_ist, sel_itest, hit;
   logic             tick, match, count_wr, set_test, clr_w1c;
   logic [RegDw-1:0] count_inc, rdata;
   logic             unused_addr;

   assign idx       = bus.addr_i[RegAw-1:2];
   assign sel_ctrl  = (idx == IdxW'(0));
   assign sel_presc = (idx == IdxW'(1));
   assign sel_count = (idx == IdxW'(2));
   assign sel_cmp   = (idx == IdxW'(3));
   assign sel_ist   = (idx == IdxW'(4));
   assign sel_itest = (idx == IdxW'(5));
   assign hit       = sel_ctrl | sel_presc | sel_count | sel_cmp | sel_ist | sel_itest;
   assign unused_addr = ^bus.addr_i[1:0];

   function automatic logic [RegDw-1:0] merge(input logic [RegDw-1:0] old,
                                              input logic [RegDw-1:0] wd,
                                              input logic [RegDw/8-1:0] be);
      logic [RegDw-1:0] r;
      r = old;
      for (int b = 0; b < RegDw/8; b++)
         if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   always_comb begin
      ctrl_d    = ctrl_q;
      presc_d   = presc_q;
      cmp_d     = cmp_q;
      tick      = ctrl_q[0] && (pcnt_q == presc_q);
      count_inc = count_q + RegDw'(1);
      count_d   = tick ? count_inc : count_q;
      count_wr  = bus.we_i && sel_count && (|bus.be_i);
      set_test  = bus.we_i && sel_itest && bus.be_i[0] && bus.wdata_i[0];
      clr_w1c   = bus.we_i && sel_ist && bus.be_i[0] && bus.wdata_i[0];

      // Prescaler restarts from zero whenever its configuration is touched.
      pcnt_d = (ctrl_q[0] && !tick) ? pcnt_q + 12'd1 : 12'd0;
      if (bus.we_i && (sel_ctrl || sel_presc)) pcnt_d = 12'd0;

      if (bus.we_i && sel_ctrl && bus.be_i[0]) ctrl_d = bus.wdata_i[1:0];
      if (bus.we_i && sel_presc) begin
         if (bus.be_i[0]) presc_d[7:0]  = bus.wdata_i[7:0];
         if (bus.be_i[1]) presc_d[11:8] = bus.wdata_i[11:8];
      end
      if (bus.we_i && sel_count) count_d = merge(count_d, bus.wdata_i, bus.be_i);
      if (bus.we_i && sel_cmp)   cmp_d   = merge(cmp_q, bus.wdata_i, bus.be_i);

      // Only a hardware increment can match; a software COUNT write masks it.
      match  = tick && !count_wr && (count_inc == cmp_q);
      intr_d = match || set_test || (intr_q && !clr_w1c);
   end

   always_comb begin
      rdata = '0;
      if (bus.re_i) begin
         if (sel_ctrl)  rdata = {{(RegDw-2){1'b0}}, ctrl_q};
         if (sel_presc) rdata = {{(RegDw-12){1'b0}}, presc_q};
         if (sel_count) rdata = count_q;
         if (sel_cmp)   rdata = cmp_q;
         if (sel_ist)   rdata = {{(RegDw-1){1'b0}}, intr_q};
      end
   end

   assign bus.rdata_o = rdata;
   assign bus.error_o = (bus.re_i || bus.we_i) && !hit;
   assign intr_o      = intr_q && ctrl_q[1];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ctrl_q  <= '0;
         presc_q <= '0;
         count_q <= '0;
         cmp_q   <= '0;
         intr_q  <= 1'b0;
         pcnt_q  <= '0;
      end else begin
         ctrl_q  <= ctrl_d;
         presc_q <= presc_d;
         count_q <= count_d;
         cmp_q   <= cmp_d;
         intr_q  <= intr_d;
         pcnt_q  <= pcnt_d;
      end
   end
endmodule

// File: tb/tb_reg_timer_core.sv
// Randomized + directed bench for reg_timer_core against a register-level reference model.
module tb_reg_timer_core;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic intr;
   int   total = 0;
   int   bad = 0;

   reg_timer_core_if #(.RegAw(8), .RegDw(32)) bus ();

   reg_timer_core #(.RegAw(8), .RegDw(32)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus),
      .intr_o(intr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  ctrl;
      logic [11:0] presc;
      logic [31:0] count;
      logic [31:0] cmp;
      logic        intr;
      logic [11:0] phase;
   } mdl_t;

   mdl_t m;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mread(input logic [7:0] a);
      case (int'(a[7:2]))
         0: return {30'd0, m.ctrl};
         1: return {20'd0, m.presc};
         2: return m.count;
         3: return m.cmp;
         4: return {31'd0, m.intr};
         default: return 32'd0;
      endcase
   endfunction

   // One clock of register-level behaviour: tick every (PRESCALE+1) enabled cycles.
   function automatic mdl_t step(input mdl_t s, input logic we, input logic [7:0] a,
                                 input logic [31:0] wd, input logic [3:0] be);
      mdl_t n = s;
      int   idx = int'(a[7:2]);
      bit   w = we && (idx <= 5);
      bit   tick = s.ctrl[0] && (s.phase == s.presc);
      bit   cw = w && idx == 2 && be != 4'd0;
      logic [31:0] inc = s.count + 32'd1;
      n.phase = (s.ctrl[0] && !tick) ? s.phase + 12'd1 : 12'd0;
      if (tick) n.count = inc;
      if (w) begin
         if (idx == 0) begin
            if (be[0]) n.ctrl = wd[1:0];
            n.phase = 0;
         end
         if (idx == 1) begin
            if (be[0]) n.presc[7:0] = wd[7:0];
            if (be[1]) n.presc[11:8] = wd[11:8];
            n.phase = 0;
         end
         for (int b = 0; b < 4; b++) begin
            if (idx == 2 && be[b]) n.count[8*b +: 8] = wd[8*b +: 8];
            if (idx == 3 && be[b]) n.cmp[8*b +: 8] = wd[8*b +: 8];
         end
      end
      n.intr = (tick && !cw && inc == s.cmp)
             || (w && idx == 5 && be[0] && wd[0])
             || (s.intr && !(w && idx == 4 && be[0] && wd[0]));
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '0;
      else        m <= step(m, bus.we_i, bus.addr_i, bus.wdata_i, bus.be_i);
   end

   always @(negedge clk) begin
      chk("rdata", bus.rdata_o, bus.re_i ? mread(bus.addr_i) : 32'd0);
      chk("error", {31'd0, bus.error_o},
          {31'd0, (bus.re_i || bus.we_i) && (bus.addr_i[7:2] > 6'd5)});
      chk("intr", {31'd0, intr}, {31'd0, m.intr && m.ctrl[1]});
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
      bus.we_i = 1'b1; bus.addr_i = a; bus.wdata_i = d; bus.be_i = be;
      @(posedge clk);
      #1;
      bus.we_i = 1'b0; bus.be_i = 4'd0;
   endtask

   task automatic rd(input string nm, input logic [7:0] a, input logic [31:0] exp,
                     input logic exp_err);
      bus.re_i = 1'b1; bus.addr_i = a;
      @(negedge clk);
      chk(nm, bus.rdata_o, exp);
      chk({nm, "_err"}, {31'd0, bus.error_o}, {31'd0, exp_err});
      @(posedge clk);
      #1;
      bus.re_i = 1'b0;
   endtask

   initial begin
      logic [31:0] r;
      logic [7:0]  a;
      logic [3:0]  be;
      logic [31:0] d;
      bus.re_i = 0; bus.we_i = 0; bus.addr_i = 0; bus.wdata_i = 0; bus.be_i = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // reset values and unmapped access
      for (int i = 0; i < 6; i++) rd("rst_read", 8'(4*i), 32'd0, 1'b0);
      rd("unmapped", 8'h18, 32'd0, 1'b1);

      // byte lanes
      wr(8'h0C, 32'hAABBCCDD, 4'hF);
      wr(8'h0C, 32'h11223344, 4'h5);
      rd("be_cmp", 8'h0C, 32'hAA22CC44, 1'b0);
      wr(8'h0C, 32'h0, 4'h0);
      rd("be_zero", 8'h0C, 32'hAA22CC44, 1'b0);

      // count every 4 cycles, then wrap
      wr(8'h04, 32'd3, 4'hF);
      wr(8'h00, 32'd1, 4'hF);
      idle(8);
      rd("count_p3_a", 8'h08, 32'd2, 1'b0);
      idle(3);
      rd("count_p3_b", 8'h08, 32'd3, 1'b0);
      wr(8'h00, 32'd0, 4'hF);
      wr(8'h04, 32'd0, 4'hF);
      wr(8'h08, 32'hFFFFFFFF, 4'hF);
      wr(8'h00, 32'd1, 4'hF);
      rd("wrap_pre", 8'h08, 32'hFFFFFFFF, 1'b0);
      rd("wrap_post", 8'h08, 32'd0, 1'b0);

      // compare interrupt
      wr(8'h00, 32'd0, 4'hF);
      wr(8'h08, 32'd0, 4'hF);
      wr(8'h0C, 32'd5, 4'hF);
      wr(8'h10, 32'd1, 4'h1);
      wr(8'h00, 32'd3, 4'hF);
      idle(4);
      chk("intr_before", {31'd0, intr}, 32'd0);
      wr(8'h00, 32'd2, 4'hF);
      chk("intr_match", {31'd0, intr}, 32'd1);
      rd("count_at_cmp", 8'h08, 32'd5, 1'b0);
      wr(8'h10, 32'd1, 4'h1);
      chk("intr_w1c", {31'd0, intr}, 32'd0);
      idle(5);
      chk("intr_idle_eq", {31'd0, intr}, 32'd0);

      // collisions
      wr(8'h00, 32'd0, 4'hF);
      wr(8'h08, 32'd0, 4'hF);
      wr(8'h0C, 32'd3, 4'hF);
      wr(8'h00, 32'd3, 4'hF);
      idle(2);
      wr(8'h10, 32'd1, 4'h1);
      rd("w1c_vs_match", 8'h10, 32'd1, 1'b0);
      wr(8'h08, 32'h100, 4'hF);
      rd("cnt_wr_vs_tick", 8'h08, 32'h100, 1'b0);
      wr(8'h00, 32'd0, 4'hF);

      // test register
      wr(8'h10, 32'd1, 4'h1);
      wr(8'h14, 32'd1, 4'h1);
      chk("test_no_irqen", {31'd0, intr}, 32'd0);
      rd("test_state", 8'h10, 32'd1, 1'b0);
      wr(8'h00, 32'd2, 4'hF);
      chk("test_irqen", {31'd0, intr}, 32'd1);
      rd("test_reads0", 8'h14, 32'd0, 1'b0);

      // reset mid-count with interrupt pending
      wr(8'h04, 32'd1, 4'hF);
      wr(8'h00, 32'd3, 4'hF);
      idle(3);
      #2 rst_n = 1'b0;
      #1 chk("rst_async_intr", {31'd0, intr}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) rd("post_rst", 8'(4*i), 32'd0, 1'b0);
      idle(4);
      rd("post_rst_cnt", 8'h08, 32'd0, 1'b0);

      // randomized traffic, checked every cycle by the compare process
      for (int i = 0; i < 3000; i++) begin
         r = $urandom;
         a = {3'd0, r[2:0], r[4:3]};
         if (r[9:6] == 4'd0) a = r[31:24];
         be = (r[10]) ? 4'hF : r[14:11];
         d = $urandom;
         case (int'(a[7:2]))
            0: d = {30'd0, r[16:15] | {1'b0, r[17] | r[18]}};
            1: d = {30'd0, r[20:19]};
            2: if (r[21]) d = m.cmp - {29'd0, r[24:22]};
            3: if (r[21]) d = m.count + {29'd0, r[24:22]};
            4, 5: d = {31'd0, r[25]};
            default: ;
         endcase
         bus.re_i = r[26];
         bus.we_i = (r[29:27] == 3'd0);
         bus.addr_i = a; bus.wdata_i = d; bus.be_i = be;
         @(posedge clk);
         #1;
      end
      bus.re_i = 0; bus.we_i = 0; bus.be_i = 0;
      idle(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
